load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side load/store unit for the uPower datapath. It accepts one decoded D-form or DS-form load/store from the execute stage, computes the effective address, and drives a request/acknowledge transaction to the 64-bit word-addressed data memory. It returns sized, extended load data to the register-file write port, and signals completion or error to the pipeline controller. One transaction is in flight at a time.

## Interface
- TIMEOUT, 16: cycles `mem_req` may stay asserted without `mem_ack` before the transaction aborts; legal range 1–65535.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  unit idle; request accepted when `req_valid && req_ready`
- opcode  in  6  primary opcode
- rt  in  5  load destination register index (ignored for stores)
- base  in  64  RA value, already zero-substituted by decode when RA=0
- disp  in  16  instruction bits [15:0]
- store_data  in  64  RS value for stores
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, valid while `mem_req`
- mem_addr  out  64  effective address, used as word index by memory
- mem_wdata  out  64  write data
- mem_rdata  in  64  read data, valid with `mem_ack`
- mem_ack  in  1  memory completion
- wb_en  out  1  one-cycle register write strobe
- wb_rd  out  5  write register index
- wb_data  out  64  write data
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies `done`: unsupported opcode or timeout

## Operation
- Supported opcodes:
  - Loads: lwz=32, lbz=34, lhz=40, lha=42, ld=58 (DS, disp[1:0]=00).
  - Stores: stw=36, stb=38, sth=44, std=62 (DS, disp[1:0]=00).
  - Anything else, including 58/62 with disp[1:0]≠00, is unsupported.
- Effective address:
  - D-form: EA = base + sext64(disp).
  - DS-form: EA = base + sext64({disp[15:2],2'b00}).
  - Modulo 2^64, wrap-around silent.
- Store data is zero-extended into the full word, matching memory semantics:
  - stb: {56'b0, sd[7:0]}
  - sth: {48'b0, sd[15:0]}
  - stw: {32'b0, sd[31:0]}
  - std: sd
- Load extension applies to `mem_rdata` low bits:
  - lbz: zero-extend [7:0]
  - lhz: zero-extend [15:0]
  - lha: sign-extend [15:0]
  - lwz: zero-extend [31:0]
  - ld: full 64 bits
- States:
  - IDLE: `req_ready`=1. On accept, capture all inputs. A supported opcode goes to ISSUE; an unsupported one goes to FIN with err.
  - ISSUE: `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata` stable. The timeout counter increments each cycle. `mem_ack` moves to FIN, capturing rdata. Counter reaching TIMEOUT without ack moves to FIN with err.
  - FIN: `done`=1 for one cycle. `wb_en`=1 only for a successful load. Then go to IDLE.
- `mem_ack` outside ISSUE is ignored.
- `req_valid` outside IDLE is not accepted.

## Timing
- Reset: state IDLE, and every output is 0 except `req_ready`=1. Reset mid-transaction drops `mem_req` at the next edge with no `done`/`wb_en`.
- Accept at edge N.
  - `mem_req` is high in cycle N+1.
  - Earliest ack is sampled at edge N+1, giving `done` in cycle N+2 and `req_ready` again in cycle N+3.
  - Latency is 2 + (ack wait) cycles.
- `wb_en`, `wb_rd`, `wb_data` and `done` are asserted together for exactly one cycle. `wb_data`/`wb_rd` are 0 when `wb_en`=0.
- Timeout:
  - With no ack in ISSUE cycles N+1…N+TIMEOUT, cycle N+TIMEOUT+1 has `done`=1, `err`=1, `mem_req`=0.
  - An ack in the final (TIMEOUT-th) ISSUE cycle wins, so there is no error.
- Unsupported opcode accepted at edge N: `done`=`err`=1 in cycle N+1, with no `mem_req`.
- `mem_addr`/`mem_wdata`/`mem_we` are 0 outside ISSUE.

## Test plan
- **lbz, zero-extend:** base=0x10, disp=0x0004, rdata=0xFFFF_FFFF_FFFF_FF80, ack after 0 wait cycles → `mem_addr`=0x14, `mem_we`=0; `done` in cycle N+2; `wb_data`=0x80 to rt.
- **lha, negative displacement:** base=0x20, disp=0xFFF8, rdata low half=0x8001 → `mem_addr`=0x18; `wb_data`=0xFFFF_FFFF_FFFF_8001.
- **stb then std:**
  - stb with store_data=0x1122_3344_5566_7788 → `mem_we`=1, `mem_wdata`=0x88; no `wb_en`.
  - std with base=0x8, disp=0x0010 → `mem_addr`=0x18, full data.
- **Ack delay and timeout (TIMEOUT=4):**
  - Ack in the 4th ISSUE cycle → success.
  - No ack → `done`=`err`=1 at N+5, `mem_req` low, no `wb_en`.
- **Unsupported opcode and busy rejection:**
  - opcode=31 → `err` pulse at N+1, no `mem_req`.
  - `req_valid` held during ISSUE is not accepted until `req_ready` returns.
- **Reset mid-ISSUE:** all outputs zero at the next edge, `req_ready`=1; a late ack after reset is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Handles one D-form or DS-form load/store at a time. It computes the
//   effective address and runs a req/ack transaction to the 64-bit data
//   memory. It returns extended load data to the register file and reports
//   done/err to the pipeline controller.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       execute-stage handshake
//   opcode, rt, base, disp,   decoded operation fields
//   store_data
//   mem_req/we/addr/wdata     memory request (driven only while in ISSUE)
//   mem_rdata, mem_ack        memory response
//   wb_en, wb_rd, wb_data     one-cycle register write port
//   done, err                 one-cycle completion pulse, err qualifies it
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt,
    input  logic [63:0] base,
    input  logic [15:0] disp,
    input  logic [63:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;

    localparam logic [5:0] OP_LWZ = 6'd32;
    localparam logic [5:0] OP_LBZ = 6'd34;
    localparam logic [5:0] OP_STW = 6'd36;
    localparam logic [5:0] OP_STB = 6'd38;
    localparam logic [5:0] OP_LHZ = 6'd40;
    localparam logic [5:0] OP_LHA = 6'd42;
    localparam logic [5:0] OP_STH = 6'd44;
    localparam logic [5:0] OP_LD  = 6'd58;
    localparam logic [5:0] OP_STD = 6'd62;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [5:0]  r_op;
    logic [4:0]  r_rt;
    logic        r_we;
    logic        r_load;
    logic        r_err;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_wb_data;
    logic [15:0] r_cnt;

    logic        w_accept;
    logic        w_ds;
    logic        w_supported;
    logic        w_is_load;
    logic [63:0] w_off;
    logic [63:0] w_ea;
    logic [63:0] w_st_ext;
    logic [63:0] w_ld_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_ds     = (opcode == OP_LD) || (opcode == OP_STD);

    // DS-form drops the low two displacement bits before sign extension.
    assign w_off = w_ds ? {{48{disp[15]}}, disp[15:2], 2'b00}
                        : {{48{disp[15]}}, disp};
    assign w_ea  = base + w_off;

    always_comb begin
        w_supported = 1'b1;
        w_is_load   = 1'b0;
        w_st_ext    = 64'd0;
        case (opcode)
            OP_LWZ, OP_LBZ, OP_LHZ, OP_LHA: w_is_load = 1'b1;
            OP_LD: begin
                w_is_load   = 1'b1;
                w_supported = (disp[1:0] == 2'b00);
            end
            OP_STB: w_st_ext = {56'd0, store_data[7:0]};
            OP_STH: w_st_ext = {48'd0, store_data[15:0]};
            OP_STW: w_st_ext = {32'd0, store_data[31:0]};
            OP_STD: begin
                w_st_ext    = store_data;
                w_supported = (disp[1:0] == 2'b00);
            end
            default: w_supported = 1'b0;
        endcase
    end

    always_comb begin
        case (r_op)
            OP_LBZ:  w_ld_ext = {56'd0, mem_rdata[7:0]};
            OP_LHZ:  w_ld_ext = {48'd0, mem_rdata[15:0]};
            OP_LHA:  w_ld_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
            OP_LWZ:  w_ld_ext = {32'd0, mem_rdata[31:0]};
            default: w_ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 6'd0;
            r_rt      <= 5'd0;
            r_we      <= 1'b0;
            r_load    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= 64'd0;
            r_wdata   <= 64'd0;
            r_wb_data <= 64'd0;
            r_cnt     <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= opcode;
                        r_rt      <= rt;
                        r_we      <= !w_is_load;
                        r_load    <= w_is_load;
                        r_addr    <= w_ea;
                        r_wdata   <= w_st_ext;
                        r_wb_data <= 64'd0;
                        r_cnt     <= 16'd0;
                        r_err     <= !w_supported;
                        r_state   <= w_supported ? S_ISSUE : S_FIN;
                    end
                end
                S_ISSUE: begin
                    // Ack is checked first so an ack in the last allowed
                    // cycle still completes cleanly.
                    if (mem_ack) begin
                        r_wb_data <= w_ld_ext;
                        r_state   <= S_FIN;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    logic w_issue;
    logic w_fin;
    assign w_issue = (r_state == S_ISSUE);
    assign w_fin   = (r_state == S_FIN);

    assign req_ready = (r_state == S_IDLE);
    assign mem_req   = w_issue;
    assign mem_we    = w_issue && r_we;
    assign mem_addr  = w_issue ? r_addr  : 64'd0;
    assign mem_wdata = w_issue ? r_wdata : 64'd0;
    assign done      = w_fin;
    assign err       = w_fin && r_err;
    assign wb_en     = w_fin && r_load && !r_err;
    assign wb_rd     = wb_en ? r_rt      : 5'd0;
    assign wb_data   = wb_en ? r_wb_data : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [63:0] base;
    logic [15:0] disp;
    logic [63:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        done;
    logic        err;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .rt(rt), .base(base), .disp(disp),
        .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [63:0] base;
        logic [15:0] disp;
        logic [63:0] sd;
        logic [63:0] rdata;
        int          wait_n;
        logic        sup;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic        wben;
        logic [63:0] wbd;
    } vec_t;

    vec_t v[12];

    task automatic drive_req(input logic [5:0] op, input logic [4:0] r, input logic [63:0] b,
                             input logic [15:0] d, input logic [63:0] sd);
        req_valid  = 1'b1;
        opcode     = op;
        rt         = r;
        base       = b;
        disp       = d;
        store_data = sd;
    endtask

    initial begin
        v[0]  = '{6'd34, 5'd5,  64'h10, 16'h0004, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0,
                  1'b1, 64'h14, 1'b0, 64'h0, 1'b1, 64'h80};
        v[1]  = '{6'd42, 5'd7,  64'h20, 16'hFFF8, 64'h0, 64'h1234_5678_9ABC_8001, 1,
                  1'b1, 64'h18, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        v[2]  = '{6'd38, 5'd9,  64'h100, 16'h0000, 64'h1122_3344_5566_7788, 64'h0, 0,
                  1'b1, 64'h100, 1'b1, 64'h88, 1'b0, 64'h0};
        v[3]  = '{6'd62, 5'd3,  64'h8, 16'h0010, 64'h1122_3344_5566_7788, 64'h0, 2,
                  1'b1, 64'h18, 1'b1, 64'h1122_3344_5566_7788, 1'b0, 64'h0};
        v[4]  = '{6'd32, 5'd1,  64'h1000, 16'h7FFF, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, TO - 1,
                  1'b1, 64'h8FFF, 1'b0, 64'h0, 1'b1, 64'hCAFE_F00D};
        v[5]  = '{6'd40, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0002, 64'h0, 64'h0123_4567_89AB_F00D, 0,
                  1'b1, 64'h1, 1'b0, 64'h0, 1'b1, 64'hF00D};
        v[6]  = '{6'd58, 5'd2,  64'h40, 16'hFFFC, 64'h0, 64'hFEDC_BA98_7654_3210, 1,
                  1'b1, 64'h3C, 1'b0, 64'h0, 1'b1, 64'hFEDC_BA98_7654_3210};
        v[7]  = '{6'd44, 5'd4,  64'h50, 16'h0001, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 0,
                  1'b1, 64'h51, 1'b1, 64'hDDDD, 1'b0, 64'h0};
        v[8]  = '{6'd36, 5'd4,  64'h0, 16'h8000, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 0,
                  1'b1, 64'hFFFF_FFFF_FFFF_8000, 1'b1, 64'hCCCC_DDDD, 1'b0, 64'h0};
        v[9]  = '{6'd31, 5'd6,  64'h10, 16'h0000, 64'h0, 64'h0, 0,
                  1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
        v[10] = '{6'd58, 5'd6,  64'h10, 16'h0005, 64'h0, 64'h0, 0,
                  1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};
        v[11] = '{6'd62, 5'd6,  64'h10, 16'h0002, 64'h0, 64'h0, 0,
                  1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0};

        rst = 1'b1; req_valid = 1'b0; opcode = '0; rt = '0; base = '0; disp = '0;
        store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_outs", {mem_req, mem_we, wb_en, done, err}, 64'd0);
        chk("rst_buses", mem_addr | mem_wdata | wb_data | {59'd0, wb_rd}, 64'd0);

        // Table-driven single transactions.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), {63'd0, req_ready}, 64'd1);
            drive_req(v[i].op, v[i].rt, v[i].base, v[i].disp, v[i].sd);
            @(negedge clk);            // cycle N+1
            req_valid = 1'b0;
            if (v[i].sup) begin
                chk($sformatf("v%0d_req", i), {62'd0, mem_req, req_ready}, 64'd2);
                chk($sformatf("v%0d_we", i), {63'd0, mem_we}, {63'd0, v[i].we});
                chk($sformatf("v%0d_addr", i), mem_addr, v[i].addr);
                chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].wdata);
                for (int w = 0; w < v[i].wait_n; w++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_wait%0d", i, w), {62'd0, mem_req, done}, 64'd2);
                end
                mem_ack = 1'b1;
                mem_rdata = v[i].rdata;
                @(negedge clk);        // FIN
                mem_ack = 1'b0;
                mem_rdata = '0;
                chk($sformatf("v%0d_done", i), {61'd0, done, err, mem_req}, 64'd4);
                chk($sformatf("v%0d_wben", i), {63'd0, wb_en}, {63'd0, v[i].wben});
                chk($sformatf("v%0d_wbrd", i), {59'd0, wb_rd}, v[i].wben ? {59'd0, v[i].rt} : 64'd0);
                chk($sformatf("v%0d_wbdata", i), wb_data, v[i].wbd);
            end else begin
                chk($sformatf("v%0d_errpulse", i), {61'd0, done, err, mem_req}, 64'd6);
                chk($sformatf("v%0d_nowb", i), {63'd0, wb_en}, 64'd0);
            end
            @(negedge clk);
            chk($sformatf("v%0d_after", i), {62'd0, done, req_ready}, 64'd1);
        end

        // Timeout: no ack for TO issue cycles.
        @(negedge clk);
        drive_req(6'd32, 5'd8, 64'h200, 16'h0, 64'h0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            chk($sformatf("to_issue%0d", k), {62'd0, mem_req, done}, 64'd2);
            @(negedge clk);
        end
        chk("to_errpulse", {61'd0, done, err, mem_req}, 64'd6);
        chk("to_nowb", {63'd0, wb_en} | wb_data, 64'd0);
        @(negedge clk);
        chk("to_after", {62'd0, done, req_ready}, 64'd1);

        // Busy rejection: req_valid stays high across the first transaction.
        drive_req(6'd34, 5'd10, 64'h300, 16'h0, 64'h0);
        @(negedge clk);            // N+1, load in ISSUE
        opcode = 6'd38; base = 64'h400; store_data = 64'h55;
        chk("busy_ready", {62'd0, req_ready, mem_we}, 64'd0);
        @(negedge clk);            // N+2, still ISSUE
        chk("busy_addr", mem_addr, 64'h300);
        mem_ack = 1'b1; mem_rdata = 64'hAB;
        @(negedge clk);            // N+3, FIN
        mem_ack = 1'b0;
        chk("busy_fin", {62'd0, wb_en, req_ready}, 64'd2);
        chk("busy_wbdata", wb_data, 64'hAB);
        @(negedge clk);            // IDLE, held request accepted at next edge
        chk("busy_ready2", {62'd0, req_ready, mem_req}, 64'd2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_second", {61'd0, mem_req, mem_we, req_ready}, 64'd6);
        chk("busy_second_wd", mem_wdata, 64'h55);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("busy_second_done", {61'd0, done, err, wb_en}, 64'd4);
        @(negedge clk);

        // Reset during ISSUE, then a late ack.
        drive_req(6'd58, 5'd12, 64'h500, 16'h0, 64'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmid_issue", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_outs", {59'd0, mem_req, mem_we, done, wb_en, err}, 64'd0);
        chk("rmid_ready", {63'd0, req_ready}, 64'd1);
        chk("rmid_addr", mem_addr, 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h77;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack", {61'd0, done, wb_en, req_ready}, 64'd1);
        chk("late_ack_wb", wb_data, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall cycle budget guard.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
